// File: rtl/acs_step_scheduler.sv
// Time-shares PAR ACS units over NUM_STATES states: one symbol per step, G issue cycles, writes lag issues by 1.
// Step period G+2 cycles (+>=1 in WAIT_TB); rx_ready only in IDLE, WAIT_TB stalls on tb_ready.
module acs_step_scheduler #(
  parameter int NUM_STATES = 64,
  parameter int PAR        = 8,
  parameter int TB_LEN     = 32,
  localparam int G         = NUM_STATES / PAR,
  localparam int GW        = (G > 1) ? $clog2(G) : 1,
  localparam int SW        = (TB_LEN > 1) ? $clog2(TB_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_rx_valid,
  input  logic [1:0]    i_rx_pair,
  output logic          o_rx_ready,
  output logic          o_acs_en,
  output logic [GW-1:0] o_acs_grp,
  output logic [1:0]    o_acs_rx,
  output logic          o_norm_sub,
  output logic          o_pm_bank,
  output logic          o_pm_we,
  output logic [GW-1:0] o_pm_wgrp,
  input  logic          i_norm_hit,
  output logic [SW-1:0] o_step_cnt,
  output logic          o_tb_start,
  input  logic          i_tb_ready
);

  localparam logic [GW-1:0] LAST_GRP  = GW'(G - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(TB_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WAIT_TB
  } state_t;

  state_t          r_state;
  logic            r_rx_ready;
  logic            r_acs_en;
  logic [GW-1:0]   r_acs_grp;
  logic [1:0]      r_acs_rx;
  logic            r_norm_sub;
  logic            r_norm_pend;
  logic            r_pm_bank;
  logic            r_pm_we;
  logic [GW-1:0]   r_pm_wgrp;
  logic [SW-1:0]   r_step_cnt;
  logic            w_accept;
  logic            w_hit;

  assign w_accept = i_rx_valid & r_rx_ready;
  assign w_hit    = r_pm_we & i_norm_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_acs_en    <= 1'b0;
      r_acs_grp   <= '0;
      r_acs_rx    <= '0;
      r_norm_sub  <= 1'b0;
      r_norm_pend <= 1'b0;
      r_pm_bank   <= 1'b0;
      r_pm_we     <= 1'b0;
      r_pm_wgrp   <= '0;
      r_step_cnt  <= '0;
    end else begin
      r_pm_we     <= r_acs_en;
      r_pm_wgrp   <= r_acs_grp;
      r_norm_pend <= r_norm_pend | w_hit;
      if (i_flush) begin
        r_state     <= S_IDLE;
        r_rx_ready  <= 1'b1;
        r_acs_en    <= 1'b0;
        r_acs_grp   <= '0;
        r_pm_we     <= 1'b0;
        r_pm_bank   <= 1'b0;
        r_step_cnt  <= '0;
        r_norm_pend <= 1'b0;
        r_norm_sub  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_acs_rx    <= i_rx_pair;
              r_norm_sub  <= r_norm_pend;
              r_norm_pend <= 1'b0;
              r_acs_en    <= 1'b1;
              r_acs_grp   <= '0;
              r_rx_ready  <= 1'b0;
              r_state     <= S_RUN;
            end else begin
              r_rx_ready  <= 1'b1;
            end
          end
          S_RUN: begin
            if (r_acs_grp == LAST_GRP) begin
              r_acs_en <= 1'b0;
              r_state  <= S_DRAIN;
            end else begin
              r_acs_grp <= r_acs_grp + GW'(1);
            end
          end
          S_DRAIN: begin
            r_pm_bank <= ~r_pm_bank;
            if (r_step_cnt == LAST_STEP) begin
              r_step_cnt <= '0;
              r_state    <= S_WAIT_TB;
            end else begin
              r_step_cnt <= r_step_cnt + SW'(1);
              r_rx_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
          S_WAIT_TB: begin
            if (i_tb_ready) begin
              r_rx_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Start must coincide with the cycle tb_ready is seen high, so it is decoded from state.
  assign o_tb_start = (r_state == S_WAIT_TB) & i_tb_ready;

  assign o_rx_ready = r_rx_ready;
  assign o_acs_en   = r_acs_en;
  assign o_acs_grp  = r_acs_grp;
  assign o_acs_rx   = r_acs_rx;
  assign o_norm_sub = r_norm_sub;
  assign o_pm_bank  = r_pm_bank;
  assign o_pm_we    = r_pm_we;
  assign o_pm_wgrp  = r_pm_wgrp;
  assign o_step_cnt = r_step_cnt;

endmodule

// File: tb/tb_acs_step_scheduler.sv
// Bench for acs_step_scheduler: vector table, directed corner sequences and a phase-based reference model.
module tb_acs_step_scheduler;
  localparam int NS  = 64;
  localparam int PAR = 8;
  localparam int TBL = 32;
  localparam int G   = NS / PAR;
  localparam int GW  = 3;
  localparam int SW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_flush, i_rx_valid, i_tb_ready, i_norm_hit;
  logic [1:0]    i_rx_pair;
  logic          o_rx_ready, o_acs_en, o_norm_sub, o_pm_bank, o_pm_we, o_tb_start;
  logic [GW-1:0] o_acs_grp, o_pm_wgrp;
  logic [1:0]    o_acs_rx;
  logic [SW-1:0] o_step_cnt;

  acs_step_scheduler #(.NUM_STATES(NS), .PAR(PAR), .TB_LEN(TBL)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_rx_valid(i_rx_valid),
    .i_rx_pair(i_rx_pair), .o_rx_ready(o_rx_ready), .o_acs_en(o_acs_en),
    .o_acs_grp(o_acs_grp), .o_acs_rx(o_acs_rx), .o_norm_sub(o_norm_sub),
    .o_pm_bank(o_pm_bank), .o_pm_we(o_pm_we), .o_pm_wgrp(o_pm_wgrp),
    .i_norm_hit(i_norm_hit), .o_step_cnt(o_step_cnt), .o_tb_start(o_tb_start),
    .i_tb_ready(i_tb_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ph = cycles since the step's accept (0 = no step in flight).
  int ph, sc, rxv;
  bit wt, rdy_ok, bank, pend, sub;

  typedef struct {
    int v, p, rdy, en, grp, rx, we, wgrp, bank, step;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_rdy();
    return (ph == 0) && !wt && rdy_ok;
  endfunction

  task automatic model_reset();
    ph = 0; sc = 0; rxv = 0; wt = 0; rdy_ok = 0; bank = 0; pend = 0; sub = 0;
  endtask

  task automatic model_update();
    bit we_now;
    bit rdy_now;
    we_now  = (ph >= 2) && (ph <= G + 1);
    rdy_now = m_rdy();
    if (i_flush) begin
      ph = 0; wt = 0; bank = 0; sc = 0; pend = 0; sub = 0;
    end else begin
      if (we_now && i_norm_hit) pend = 1;
      if (rdy_now && i_rx_valid) begin
        rxv = i_rx_pair; sub = pend; pend = 0; ph = 1;
      end else if (ph >= 1 && ph <= G) begin
        ph++;
      end else if (ph == G + 1) begin
        ph = 0;
        bank = ~bank;
        if (sc == TBL - 1) begin sc = 0; wt = 1; end
        else sc++;
      end else if (wt && i_tb_ready) begin
        wt = 0;
      end
    end
    rdy_ok = 1;
  endtask

  task automatic model_check();
    bit exp_en;
    bit exp_we;
    exp_en = (ph >= 1) && (ph <= G);
    exp_we = (ph >= 2) && (ph <= G + 1);
    chk("rx_ready", o_rx_ready, m_rdy());
    chk("acs_en", o_acs_en, exp_en);
    if (exp_en) chk("acs_grp", o_acs_grp, ph - 1);
    chk("acs_rx", o_acs_rx, rxv);
    chk("norm_sub", o_norm_sub, sub);
    chk("pm_we", o_pm_we, exp_we);
    if (exp_we) chk("pm_wgrp", o_pm_wgrp, ph - 2);
    chk("pm_bank", o_pm_bank, bank);
    chk("step_cnt", o_step_cnt, sc);
    chk("tb_start", o_tb_start, wt && i_tb_ready);
  endtask

  task automatic drive(input bit f, input bit v, input int p, input bit t, input bit h);
    i_flush = f; i_rx_valid = v; i_rx_pair = p[1:0]; i_tb_ready = t; i_norm_hit = h;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit f, input bit v, input int p, input bit t, input bit h);
    drive(f, v, p, t, h);
    #1;
    model_check();
    model_update();
    clk_step();
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, "_rx_ready"}, o_rx_ready, 0);
    chk({pre, "_acs_en"}, o_acs_en, 0);
    chk({pre, "_acs_grp"}, o_acs_grp, 0);
    chk({pre, "_acs_rx"}, o_acs_rx, 0);
    chk({pre, "_norm_sub"}, o_norm_sub, 0);
    chk({pre, "_pm_bank"}, o_pm_bank, 0);
    chk({pre, "_pm_we"}, o_pm_we, 0);
    chk({pre, "_pm_wgrp"}, o_pm_wgrp, 0);
    chk({pre, "_step_cnt"}, o_step_cnt, 0);
    chk({pre, "_tb_start"}, o_tb_start, 0);
  endtask

  // Entered right after reset release, in the first post-release cycle.
  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      drive(0, tbl[i].v[0], tbl[i].p, 1, 0);
      #1;
      chk($sformatf("tbl%0d_rdy", i), o_rx_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_en", i), o_acs_en, tbl[i].en);
      if (tbl[i].en != 0) begin
        chk($sformatf("tbl%0d_grp", i), o_acs_grp, tbl[i].grp);
        chk($sformatf("tbl%0d_rx", i), o_acs_rx, tbl[i].rx);
      end
      chk($sformatf("tbl%0d_we", i), o_pm_we, tbl[i].we);
      if (tbl[i].we != 0) chk($sformatf("tbl%0d_wgrp", i), o_pm_wgrp, tbl[i].wgrp);
      chk($sformatf("tbl%0d_bank", i), o_pm_bank, tbl[i].bank);
      chk($sformatf("tbl%0d_step", i), o_step_cnt, tbl[i].step);
      model_update();
      clk_step();
    end
  endtask

  task automatic run_step(input int hg, output int subcnt);
    bit acc;
    bit v;
    int n;
    acc = 0; n = 0; subcnt = 0;
    while (!(acc && ph == 0 && !wt) && n < 40) begin
      v = !acc;
      drive(0, v, 3, 1, (hg >= 0) && (ph == hg + 2));
      #1;
      if (o_acs_en && o_norm_sub) subcnt++;
      if (m_rdy() && v) acc = 1;
      model_check();
      model_update();
      clk_step();
      n++;
    end
    chk("step_completed", acc, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc_t[$];
    int t, pulses, cnt_rdy, cnt_tbs, sc0, sc1, sc2, n;
    bit f, done;

    tbl = '{
      '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0},
      '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 1, 0, 2, 0, 0, 0, 0},
      '{0, 0, 0, 1, 1, 2, 1, 0, 0, 0},
      '{0, 0, 0, 1, 2, 2, 1, 1, 0, 0},
      '{0, 0, 0, 1, 3, 2, 1, 2, 0, 0},
      '{0, 0, 0, 1, 4, 2, 1, 3, 0, 0},
      '{0, 0, 0, 1, 5, 2, 1, 4, 0, 0},
      '{0, 0, 0, 1, 6, 2, 1, 5, 0, 0},
      '{0, 0, 0, 1, 7, 2, 1, 6, 0, 0},
      '{0, 0, 0, 0, 0, 0, 1, 7, 0, 0},
      '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1}
    };

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_table();

    // Back-to-back symbols over a full window, traceback always ready.
    cyc(1, 0, 0, 1, 0);
    t = 0; pulses = 0;
    while (acc_t.size() < 33 && t < 500) begin
      drive(0, 1, $urandom_range(0, 3), 1, 0);
      #1;
      if (o_rx_ready) acc_t.push_back(t);
      if (o_tb_start) pulses++;
      model_check();
      model_update();
      clk_step();
      t++;
    end
    chk("s2_accepts", acc_t.size(), 33);
    for (int k = 1; k < acc_t.size(); k++)
      chk($sformatf("s2_gap%0d", k), acc_t[k] - acc_t[k-1], (k == 32) ? 11 : 10);
    chk("s2_tb_pulses", pulses, 1);
    chk("s2_step_cnt", o_step_cnt, 0);
    chk("s2_pm_bank", o_pm_bank, 0);

    // Window end with traceback busy for 20 cycles.
    cyc(1, 0, 0, 0, 0);
    n = 0;
    while (!wt && n < 400) begin
      cyc(0, 1, $urandom_range(0, 3), 0, 0);
      n++;
    end
    chk("s3_reached_wait", wt, 1);
    cnt_rdy = 0; cnt_tbs = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 0, 0);
      #1;
      if (o_rx_ready) cnt_rdy++;
      if (o_tb_start) cnt_tbs++;
      model_check();
      model_update();
      clk_step();
    end
    chk("s3_rdy_while_wait", cnt_rdy, 0);
    chk("s3_tbs_while_wait", cnt_tbs, 0);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("s3_tb_start_pulse", o_tb_start, 1);
    model_update();
    clk_step();
    drive(0, 0, 0, 1, 0);
    #1;
    chk("s3_tb_start_after", o_tb_start, 0);
    chk("s3_rdy_after", o_rx_ready, 1);
    model_update();
    clk_step();

    // Normalization request carried into the following step only.
    cyc(1, 0, 0, 1, 0);
    run_step(5, sc0);
    run_step(-1, sc1);
    run_step(-1, sc2);
    chk("s4_sub_step_n", sc0, 0);
    chk("s4_sub_step_n1", sc1, G);
    chk("s4_sub_step_n2", sc2, 0);

    // Flush in the middle of an issue sequence.
    run_step(-1, sc0);
    done = 0; n = 0;
    while (!done && n < 40) begin
      f = (ph == 4);
      drive(f, ph == 0, 1, 1, 0);
      #1;
      if (f) chk("s5_grp_at_flush", o_acs_grp, 3);
      model_check();
      model_update();
      clk_step();
      n++;
      done = f;
    end
    chk("s5_flush_applied", done, 1);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("s5_acs_en", o_acs_en, 0);
    chk("s5_pm_we", o_pm_we, 0);
    chk("s5_pm_bank", o_pm_bank, 0);
    chk("s5_step_cnt", o_step_cnt, 0);
    chk("s5_rx_ready", o_rx_ready, 1);
    model_update();
    clk_step();

    // Asynchronous reset while a step is draining.
    n = 0;
    while (ph != G + 1 && n < 40) begin
      cyc(0, ph == 0, 3, 1, 0);
      n++;
    end
    drive(0, 0, 0, 1, 0);
    #1;
    chk("s6_drain_we", o_pm_we, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("s6");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_table();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, $urandom_range(0, 3),
          $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/acs_step_scheduler.md
Name: acs_step_scheduler

Overview:
- Sequences one time-shared bank of PAR branch-metric/ACS units across all NUM_STATES trellis states of the 64-state Viterbi decoder, one received symbol pair per trellis step.
- Accepts rx_pair through a valid/ready handshake and issues state groups to the ACS bank.
- Controls ping-pong path-metric bank selection, write strobes and metric normalization.
- Raises traceback start every TB_LEN steps.

Parameters:
NUM_STATES, 64, trellis states; power of two.
PAR, 8, ACS units in the bank; power of two, divides NUM_STATES.
TB_LEN, 32, trellis steps between traceback starts; ≥2.
(Derived, not overridable: G = NUM_STATES/PAR; GW = max(1,log2(G)); SW = log2(TB_LEN).)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous frame restart, highest priority
rx_valid  in  1  symbol pair valid
rx_pair  in  2  received hard-decision pair
rx_ready  out  1  scheduler can accept a symbol
acs_en  out  1  ACS bank issue strobe
acs_grp  out  GW  state group issued
acs_rx  out  2  symbol pair held for the current step
norm_sub  out  1  subtract normalization offset in this step's ACS
pm_bank  out  1  path-metric read bank; write bank = ~pm_bank
pm_we  out  1  path-metric/survivor write strobe
pm_wgrp  out  GW  group being written
norm_hit  in  1  datapath: a written metric exceeds threshold; sampled only when pm_we=1
step_cnt  out  SW  trellis step index within the traceback window
tb_start  out  1  one-cycle traceback start pulse
tb_ready  in  1  traceback unit can accept a start

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, rx_ready=0, acs_en=0, acs_grp=0, acs_rx=0, norm_sub=0, pm_bank=0, pm_we=0, pm_wgrp=0, step_cnt=0, tb_start=0, internal norm_pend=0.
- rx_ready is a registered output. It equals 1 exactly when state=IDLE, and reads 0 in the first cycle after reset release.
- FSM states: IDLE, RUN, DRAIN, WAIT_TB.
- IDLE: handshake on rx_valid&rx_ready.
  - Latch acs_rx<=rx_pair.
  - norm_sub<=norm_pend, then clear norm_pend.
  - grp<=0; go RUN.
- RUN: acs_en=1, acs_grp=grp; grp increments each cycle.
  - After issuing grp=G-1, go DRAIN.
  - acs_rx and norm_sub are constant for the whole step.
- Write latency = 1 cycle: pm_we and pm_wgrp are acs_en and acs_grp registered.
  - Exactly G pm_we pulses per step, groups 0..G-1 in order.
- norm_hit sampled in any cycle with pm_we=1 sets norm_pend (sticky). It affects the next step only.
- DRAIN (one cycle; carries last write pm_wgrp=G-1). At exit:
  - Toggle pm_bank.
  - step_cnt wraps TB_LEN-1 -> 0.
  - If the old step_cnt == TB_LEN-1: go to WAIT_TB; otherwise go to IDLE.
- WAIT_TB: tb_start=1 for exactly the one cycle in which tb_ready=1, then go IDLE.
  - If tb_ready is already 1 on entry, tb_start fires in that first WAIT_TB cycle.
  - Stall indefinitely while tb_ready=0; rx_ready stays 0.
- Step period is G+2 cycles minimum: IDLE accept, G issue, DRAIN. WAIT_TB adds ≥1 cycle.
- flush (any state, synchronous):
  - Next cycle: state=IDLE, acs_en=0, pm_we=0 (an in-flight write is suppressed).
  - pm_bank=0, step_cnt=0, norm_pend=0, norm_sub=0, tb_start=0.
  - flush dominates a coincident rx handshake: the symbol is not taken.
- G=1: RUN lasts one cycle with acs_grp=0.
- rx_valid while rx_ready=0 is ignored; the source holds data.
- Reset asserted mid-step: all outputs return to reset values immediately; no partial write completes.

Test Plan:
- Single symbol after reset, defaults, rx_pair=2'b10 -> acs_en high 8 cycles, acs_grp 0..7, acs_rx=2'b10; pm_we 8 cycles lagging by 1; pm_bank 0->1 after DRAIN; step_cnt=1; rx_ready back high at cycle 10 after accept.
- Back-to-back rx_valid held high for 32 symbols, tb_ready=1 -> one accept every 10 cycles for steps 0..30; 32nd step -> tb_start single pulse, step_cnt=0, pm_bank=0, next accept delayed 1 extra cycle.
- Same as previous, but tb_ready=0 for 20 cycles at window end -> scheduler holds WAIT_TB, rx_ready=0, no tb_start until tb_ready rises, then exactly one pulse.
- norm_hit=1 during pm_we for group 5 of step n -> norm_sub=0 throughout step n and 1 for all 8 issues of step n+1; norm_sub=0 in step n+2 if no further hit.
- flush asserted during RUN at acs_grp=3 -> next cycle acs_en=0, pm_we=0, pm_bank=0, step_cnt=0, rx_ready=1 the cycle after.
- rst_n pulsed low asynchronously mid-DRAIN -> all outputs zero without waiting for clk; after release, first accept behaves as the first scenario.
